// File: rtl/pulse_seq_pkg.sv
// Shared register map and channel state encoding for the multi-channel pulse sequencer.
package pulse_seq_pkg;

    localparam logic [2:0] REG_INIT_COUNT = 3'd0;
    localparam logic [2:0] REG_HI_COUNT   = 3'd1;
    localparam logic [2:0] REG_LO_COUNT   = 3'd2;
    localparam logic [2:0] REG_INIT_STATE = 3'd3;
    localparam logic [2:0] REG_BURST      = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_seq_chan.sv
// One pulse-train channel: programming registers, phase down-counter, burst counter and IDLE/RUN FSM.
module pulse_seq_chan
    import pulse_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_value,
    input  logic             start,
    input  logic             stop,
    input  logic             operate,
    output logic             out,
    output logic             running,
    output logic             done
);

    logic [WIDTH-1:0] init_count, hi_count, lo_count;
    logic             init_state;
    logic [BW-1:0]    burst;

    state_e           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [BW-1:0]    pulses, pulses_nxt, pulses_inc;
    logic             out_nxt, done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            init_count <= '0;
            hi_count   <= '0;
            lo_count   <= '0;
            init_state <= 1'b0;
            burst      <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                REG_INIT_COUNT: init_count <= wr_value;
                REG_HI_COUNT:   hi_count   <= wr_value;
                REG_LO_COUNT:   lo_count   <= wr_value;
                REG_INIT_STATE: init_state <= wr_value[0];
                REG_BURST:      burst      <= wr_value[BW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            pulses <= '0;
            out    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            pulses <= pulses_nxt;
            out    <= out_nxt;
            done   <= done_nxt;
        end
    end

    // stop beats start; a count of 0 reloads, so the counter never wraps
    always_comb begin
        pulses_inc = pulses + BW'(1);
        state_nxt  = state;
        count_nxt  = count;
        pulses_nxt = pulses;
        out_nxt    = out;
        done_nxt   = 1'b0;
        if (stop) begin
            if (state == ST_RUN) begin
                state_nxt = ST_IDLE;
                out_nxt   = init_state;
            end
        end else if (start) begin
            state_nxt  = ST_RUN;
            count_nxt  = init_count;
            out_nxt    = init_state;
            pulses_nxt = '0;
        end else if (state == ST_RUN && operate) begin
            if (count == '0) begin
                out_nxt   = ~out;
                count_nxt = out ? lo_count : hi_count;
                if (out) begin
                    pulses_nxt = pulses_inc;
                    // >= so a BURST lowered mid-run ends at the next falling edge
                    if (burst != '0 && pulses_inc >= burst) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end else begin
                count_nxt = count - WIDTH'(1);
            end
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: rtl/pulse_seq_multi.sv
// NCH-channel pulse-train generator: shared register write port decoded onto per-channel sequencers.
module pulse_seq_multi
    import pulse_seq_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int BW    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [(NCH>1 ? $clog2(NCH) : 1)-1:0] wr_chan,
    input  logic [2:0]                           wr_addr,
    input  logic [WIDTH-1:0]                     wr_value,
    input  logic [NCH-1:0]                       start,
    input  logic [NCH-1:0]                       stop,
    input  logic                                 operate,
    output logic [NCH-1:0]                       out,
    output logic [NCH-1:0]                       running,
    output logic [NCH-1:0]                       done
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] chan_wr;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign chan_wr[i] = wr_en && (NCH == 1 || wr_chan == CW'(i));

        pulse_seq_chan #(.WIDTH(WIDTH), .BW(BW)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (chan_wr[i]),
            .wr_addr  (wr_addr),
            .wr_value (wr_value),
            .start    (start[i]),
            .stop     (stop[i]),
            .operate  (operate),
            .out      (out[i]),
            .running  (running[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_pulse_seq_multi.sv
// Directed bench: driver pushes hand-computed per-cycle expectations; negedge monitor pops and compares.
module tb_pulse_seq_multi;
    import pulse_seq_pkg::*;

    localparam int NCH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [1:0]       wr_chan;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_value;
    logic [NCH-1:0]   start, stop;
    logic             operate;
    logic [NCH-1:0]   out, running, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NCH-1:0] mask, o, r, d;
        string          name;
    } exp_t;
    exp_t sb[$];

    pulse_seq_multi #(.NCH(NCH), .WIDTH(WIDTH), .BW(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr),
        .wr_value(wr_value), .start(start), .stop(stop), .operate(operate),
        .out(out), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (((out & e.mask) !== e.o) || ((running & e.mask) !== e.r) || ((done & e.mask) !== e.d)) begin
                errors++;
                $display("FAIL %s: out/running/done = %b/%b/%b, expected %b/%b/%b (mask %b)",
                         e.name, out & e.mask, running & e.mask, done & e.mask, e.o, e.r, e.d, e.mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = '0;
        stop  = '0;
        wr_en = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [2:0] addr, input logic [WIDTH-1:0] val);
        wr_en    = 1'b1;
        wr_chan  = 2'(ch);
        wr_addr  = addr;
        wr_value = val;
        tick();
    endtask

    task automatic chk_all(input string name, input logic [NCH-1:0] o, r, d);
        exp_t e;
        tick();
        e.mask = '1; e.o = o; e.r = r; e.d = d; e.name = name;
        sb.push_back(e);
    endtask

    // '0'/'1': running with that out; 'D': burst-end cycle; 'i'/'I': idle with out 0/1
    task automatic run_pat(input int ch, input string pat, input string name);
        for (int i = 0; i < pat.len(); i++) begin
            exp_t e;
            logic o, r, d;
            byte  c;
            c = pat[i];
            o = (c == "1" || c == "I");
            r = (c == "0" || c == "1");
            d = (c == "D");
            tick();
            e.mask = NCH'(1) << ch;
            e.o = o ? e.mask : '0;
            e.r = r ? e.mask : '0;
            e.d = d ? e.mask : '0;
            e.name = $sformatf("%s[%0d]", name, i);
            sb.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_addr = '0; wr_value = '0;
        start = '0; stop = '0; operate = 1'b1;
        chk_all("reset", '0, '0, '0);
        reset = 1'b0;
        chk_all("post_reset", '0, '0, '0);

        // 1: continuous 3 high / 2 low after one low cycle
        wr(0, REG_INIT_COUNT, 0); wr(0, REG_HI_COUNT, 2); wr(0, REG_LO_COUNT, 1);
        wr(0, REG_INIT_STATE, 0); wr(0, REG_BURST, 0);
        start[0] = 1'b1; run_pat(0, "011100111001110", "t1");
        stop[0] = 1'b1;  run_pat(0, "i", "t1stop");

        // 2: burst of 3 single-cycle pulses
        wr(1, REG_HI_COUNT, 0); wr(1, REG_LO_COUNT, 0); wr(1, REG_BURST, 3);
        start[1] = 1'b1; run_pat(1, "010101Dii", "t2");

        // 3: stop in high phase returns INIT_STATE=1 without done
        wr(2, REG_HI_COUNT, 4); wr(2, REG_LO_COUNT, 2); wr(2, REG_INIT_STATE, 1);
        start[2] = 1'b1; run_pat(2, "100011", "t3");
        stop[2] = 1'b1;  run_pat(2, "II", "t3stop");
        stop[2] = 1'b1;  run_pat(2, "I", "t3idle");

        // 4: operate low freezes mid-phase
        wr(3, REG_INIT_COUNT, 1); wr(3, REG_HI_COUNT, 3); wr(3, REG_LO_COUNT, 3);
        start[3] = 1'b1; run_pat(3, "0011", "t4a");
        operate = 1'b0;  run_pat(3, "11111", "t4hold");
        operate = 1'b1;  run_pat(3, "110000111", "t4b");

        // 5: start+stop, restart while running
        start[1] = 1'b1; stop[1] = 1'b1; run_pat(1, "ii", "t5ss_idle");
        start[3] = 1'b1; run_pat(3, "0011", "t5restart");
        start[3] = 1'b1; stop[3] = 1'b1; run_pat(3, "ii", "t5ss_run");

        // HI rewritten during high phase only affects the next high phase
        start[0] = 1'b1; run_pat(0, "01", "thi_a");
        wr_en = 1'b1; wr_chan = 2'd0; wr_addr = REG_HI_COUNT; wr_value = 7;
        run_pat(0, "1", "thi_wr");
        run_pat(0, "100111111110", "thi_b");

        // 6: reset mid-burst beats a concurrent write and start
        wr(1, REG_BURST, 5);
        start[1] = 1'b1; run_pat(1, "0101", "t6a");
        reset = 1'b1; wr_en = 1'b1; wr_chan = 2'd1; wr_addr = REG_HI_COUNT; wr_value = 9; start = '1;
        chk_all("t6reset", '0, '0, '0);
        reset = 1'b0;
        start[1] = 1'b1; run_pat(1, "010101010101", "t6regs0");
        start[2] = 1'b1; run_pat(2, "0", "t6state0");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
